// File: rtl/sim_ctrl_pkg.sv
// Shared types and parameter defaults for the simulation run controller.
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PASS    = 3'd3,
        ST_TIMEOUT = 3'd4
    } sim_state_e;

    localparam int unsigned DEF_RESET_CYCLES   = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;
    localparam int unsigned DEF_DUMP_START     = 0;
    localparam int unsigned DEF_SEGMENT_CYCLES = 5000;
    localparam int unsigned DEF_MAX_FILES      = 100;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dump_segmenter.sv
// Splits the dump window into fixed-length segments and tracks the dump file index.
module dump_segmenter
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned SEGMENT_CYCLES = DEF_SEGMENT_CYCLES,
    parameter int unsigned MAX_FILES      = DEF_MAX_FILES,
    parameter int unsigned IW             = idx_width(MAX_FILES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          dump_en,
    output logic          dump_switch,
    output logic [IW-1:0] dump_file_idx
);

    logic [31:0] seg_cnt;

    // The switch is registered, so a segment ending on the last RUN cycle still pulses.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            seg_cnt       <= '0;
            dump_switch   <= 1'b0;
            dump_file_idx <= '0;
        end else begin
            dump_switch <= 1'b0;
            if (dump_en) begin
                if (seg_cnt == 32'(SEGMENT_CYCLES - 1)) begin
                    seg_cnt       <= '0;
                    dump_switch   <= 1'b1;
                    dump_file_idx <= (dump_file_idx == IW'(MAX_FILES - 1)) ? '0
                                                                         : dump_file_idx + 1'b1;
                end else begin
                    seg_cnt <= seg_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Sequences harness reset, run, pass/timeout status and waveform dump windows.
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned DUMP_START     = DEF_DUMP_START,
    parameter int unsigned SEGMENT_CYCLES = DEF_SEGMENT_CYCLES,
    parameter int unsigned MAX_FILES      = DEF_MAX_FILES,
    parameter int unsigned IW             = idx_width(MAX_FILES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          success,
    output logic          dut_reset,
    output logic          run_active,
    output logic [31:0]   cycle_count,
    output logic          dump_en,
    output logic          dump_switch,
    output logic [IW-1:0] dump_file_idx,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output sim_state_e    state
);

    localparam int unsigned HW = idx_width(RESET_CYCLES);

    logic [HW-1:0] hold_cnt;
    logic          clear;

    // Any accepted start request restarts the dump segmentation from file 0.
    assign clear = start && (state == ST_IDLE || state == ST_PASS || state == ST_TIMEOUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_PASS, ST_TIMEOUT: begin
                    if (start) begin
                        state       <= ST_HOLD;
                        hold_cnt    <= '0;
                        cycle_count <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
                        state <= ST_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (success) begin
                        state <= ST_PASS;
                    end else if (cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
                        state <= ST_TIMEOUT;
                    end else begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dut_reset  = (state == ST_IDLE) || (state == ST_HOLD);
    assign run_active = (state == ST_RUN);
    assign pass       = (state == ST_PASS);
    assign timeout    = (state == ST_TIMEOUT);
    assign done       = pass || timeout;
    assign dump_en    = run_active && (cycle_count >= 32'(DUMP_START));

    dump_segmenter #(
        .SEGMENT_CYCLES (SEGMENT_CYCLES),
        .MAX_FILES      (MAX_FILES),
        .IW             (IW)
    ) u_segmenter (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .dump_en       (dump_en),
        .dump_switch   (dump_switch),
        .dump_file_idx (dump_file_idx)
    );

endmodule
